// File: rtl/div_seq.sv
// Multi-cycle restoring radix-2 integer divider: quotient to lo, remainder to hi.
// Signed (div) and unsigned (divu) modes, start/busy/done handshake, divide-by-zero flag.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; B == 0 is answered here with div_zero/done
// CALC  | one quotient bit per clock, WIDTH iterations
// FIX   | sign correction, hi/lo write, done pulse, back to IDLE
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             fits;

    assign a_neg = is_signed & A[WIDTH-1];
    assign b_neg = is_signed & B[WIDTH-1];
    // Most-negative input negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
    assign a_mag = a_neg ? (~A + 1'b1) : A;
    assign b_mag = b_neg ? (~B + 1'b1) : B;

    // Shifted remainder is one bit wider; the top bit of the difference is the borrow.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs};
    assign fits   = ~diff[WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            quo      <= '0;
            dvs      <= '0;
            rem      <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (B == '0) begin
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            sa    <= a_neg;
                            sb    <= b_neg;
                            quo   <= a_mag;
                            dvs   <= b_mag;
                            rem   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem <= fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], fits};
                    cnt <= cnt + 1'b1;
                    // busy drops as the last iteration completes, so it spans exactly WIDTH cycles.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        busy  <= 1'b0;
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    lo       <= (sa ^ sb) ? (~quo + 1'b1) : quo;
                    hi       <= sa ? (~rem + 1'b1) : rem;
                    div_zero <= 1'b0;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table plus hand sequences for
// ignored start, back-to-back start, and reset mid-operation.
`timescale 1ns/1ps
module tb_div_seq;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    div_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .is_signed(is_signed),
        .A        (A),
        .B        (B),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] exp_lo;
        logic [W-1:0] exp_hi;
        logic         exp_dz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one request and wait for done. lat = clocks from the sampling edge to done.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input int poke_cyc, input bit check_drop,
                           output int lat, output int bcnt);
        @(negedge clk);
        A = a; B = b; is_signed = s; start = 1'b1;
        lat  = -1;
        bcnt = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                start = 1'b0;
                A = $urandom; B = $urandom; is_signed = ~s;
            end
            if (busy) bcnt++;
            if (n == poke_cyc) begin
                start = 1'b1; A = 32'd100; B = 32'd7; is_signed = 1'b0;
            end
            if (n == poke_cyc + 1) start = 1'b0;
            if (done) begin
                lat = n - 1;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no done within 100 clocks, expected one");
        end
        if (check_drop) begin
            @(posedge clk); #1;
            check("done_one_cycle", done, 0);
        end
    endtask

    int lat;
    int bcnt;
    int seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0};
        vecs[1]  = '{32'd5,        32'd0,        1'b0, 32'd14,       32'd2,        1'b1};
        vecs[2]  = '{32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
        vecs[3]  = '{32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,        1'b0};
        vecs[4]  = '{32'hFFFFFFFF, 32'd2,        1'b0, 32'h7FFFFFFF, 32'd1,        1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'd2,        1'b1, 32'd0,        32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0};
        vecs[7]  = '{32'd7,        32'd100,      1'b0, 32'd0,        32'd7,        1'b0};
        vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        32'd0,        1'b0};
        vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0};
        vecs[10] = '{32'd3,        32'd0,        1'b1, 32'd0,        32'h80000000, 1'b1};

        reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_div_zero", div_zero, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].s, -1, 1'b1, lat, bcnt);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_div_zero", i), div_zero, vecs[i].exp_dz);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_dz ? 0 : 33);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].exp_dz ? 0 : 32);
        end

        // Signed overflow with a second start injected while busy; it must be ignored.
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 10, 1'b1, lat, bcnt);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 0);
        check("ovf_div_zero", div_zero, 0);
        check("ovf_latency", lat, 33);
        @(posedge clk); #1;
        check("ovf_no_queued_busy", busy, 0);

        // Back-to-back: the second start is issued during the done cycle of the first.
        run_div(32'd1000, 32'd10, 1'b0, -1, 1'b0, lat, bcnt);
        check("b2b_first_lo", lo, 100);
        run_div(32'd1001, 32'd10, 1'b1, -1, 1'b1, lat, bcnt);
        check("b2b_second_lo", lo, 100);
        check("b2b_second_hi", hi, 1);
        check("b2b_second_latency", lat, 33);

        // Set div_zero so the reset below has something non-zero to clear.
        run_div(32'd5, 32'd0, 1'b0, -1, 1'b1, lat, bcnt);
        check("pre_reset_div_zero", div_zero, 1);

        @(negedge clk);
        A = 32'd100; B = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("mid_busy_before_reset", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_reset_hi", hi, 0);
        check("mid_reset_lo", lo, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_done", done, 0);
        check("mid_reset_div_zero", div_zero, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("no_activity_after_reset", seen, 0);

        run_div(32'd9, 32'd3, 1'b0, -1, 1'b1, lat, bcnt);
        check("post_reset_lo", lo, 3);
        check("post_reset_hi", hi, 0);
        check("post_reset_latency", lat, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
